bpu_train_queue: RTL
====================

// Module: bpu_train_queue
// PURPOSE
//  Buffers branch-predictor training updates (BHT counter + BTB writes) leaving the int writeback
//  pipe register and drains them into the frontend predictor whenever its SRAM port is free.
//  Fetch lookups own the predictor port, so training must wait without stalling writeback;
//  updates arriving while the queue is full are dropped and counted (training is a hint only).
// PARAMETERS
//  DEPTH      4   entries; power of two, >= 2
//  BHT_IDX_W  9   BHT index width (= `BHTBTB_INDEX_WIDTH)
//  DROP_W     8   width of saturating drop counter
// PORTS
//  clock          in   1              core clock
//  reset_n        in   1              asynchronous active-low reset
//  in_bht_pkt     in   BHT_IDX_W+6    {write_enable, write_index, counter_select[1:0], inc, dec, valid_in} from intwb_bjusb_bht_*
//  in_btb_pkt     in   269            {ce, we, wmask[128:0], write_index[8:0], din[128:0]} from intwb_bjusb_btb_*
//  train_valid    out  1              head entry presented to predictor
//  train_ready    in   1              predictor port free this cycle (low during fetch lookup)
//  out_bht_pkt    out  BHT_IDX_W+6    head BHT update, same layout as in_bht_pkt
//  out_btb_pkt    out  269            head BTB update, same layout as in_btb_pkt
//  occupancy      out  $clog2(DEPTH)+1  current number of queued entries
//  drop_cnt       out  DROP_W         updates lost to full queue, saturating
// BEHAVIOUR
//  - Reset (async, reset_n=0): pointers=0, occupancy=0, drop_cnt=0, train_valid=0, out pkts=0.
//    Storage array is not reset; entries held at reset are discarded. Reset mid-drain -> nothing replayed.
//  - accept = in_bht_pkt.write_enable | (in_btb_pkt.ce & in_btb_pkt.we). Non-accept cycles ignored.
//  - One entry = one cycle's {bht_pkt, btb_pkt} pair, stored whole; the inner enables gate the predictor.
//  - deq = train_valid & train_ready. enq = accept & (!full | deq).
//  - drop = accept & full & !deq -> drop_cnt += 1, holds at 2^DROP_W-1.
//  - Pointers are $clog2(DEPTH)+1 bits with wrap bit; empty: ptrs equal; full: equal except MSB.
//    Wrap from DEPTH-1 to 0 is seamless.
//  - Latency: entry enqueued in cycle t is at head (train_valid=1) in cycle t+1 at earliest. No bypass.
//  - train_valid = !empty. It never depends combinationally on train_ready.
//  - Out pkts = head entry when valid, else all-zero, so no spurious enable ever reaches the predictor.
//  - Head holds stable while train_valid & !train_ready.
//  - Simultaneous enq+deq: allowed at any occupancy, including full (occupancy unchanged) and
//    empty->1->0 (the new entry appears next cycle).
//  - FIFO order is strict; no coalescing of same-index updates.
//  - Redirect/flush does not affect the queue: queued updates come from already-resolved branches.
//  - occupancy = wr_ptr - rd_ptr (modular), registered-state derived.
// STRUCTURE
//  - Package bpu_train_pkg:
//    - typedef struct packed bht_upd_t {we, idx, sel, inc, dec, vld}
//    - typedef struct packed btb_upd_t {ce, we, wmask, idx, din}
//    - localparams BTB_W=129, BTB_IDX_W=9
//    - localparam BHT_UPD_W, BTB_UPD_W
//  - Sub-module sync_fifo #(DEPTH, WIDTH): storage, wrap-bit pointers, full/empty, occupancy.
//  - Top level adds accept decode, drop counter and output zero-gating.
// TESTING
//  1. Reset with queue holding 3 entries -> next cycle train_valid=0, occupancy=0, out pkts=0, drop_cnt=0.
//  2. Single BHT update idx=0x1A5, sel=2, inc=1, ready=1 -> train_valid=1 one cycle later,
//     out_bht_pkt matches; occupancy 1->0 after the handshake.
//  3. ready=0, push 6 accepted updates with DEPTH=4 -> occupancy=4, drop_cnt=2;
//     ready=1 -> first 4 emerge in order, then train_valid=0.
//  4. Full queue, accept & ready same cycle -> enqueued, drop_cnt unchanged, occupancy stays 4;
//     order preserved across pointer wrap.
//  5. in_btb_pkt ce=1 we=0 and bht write_enable=0 -> no enqueue; ce=1 we=1 wmask=all-ones
//     din=0x1_DEAD_BEEF -> enqueued, emerges intact.
//  6. 300 drops with ready=0 -> drop_cnt saturates at 255; ready toggling randomly never changes
//     the head while stalled.

Source files
------------

// File: rtl/bpu_train_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bpu_train_pkg
//  Purpose  : Shared types and widths for the branch-predictor training queue.
//             Describes one BHT counter update and one BTB write as leaving the
//             int writeback pipe register.
//  Contents : bht_upd_t, btb_upd_t, width localparams, accept decode helper.
//  Revision : 1.0 - initial release
// ============================================================================
package bpu_train_pkg;

    localparam int BHT_IDX_W = 9;
    localparam int BTB_W     = 129;
    localparam int BTB_IDX_W = 9;

    typedef struct packed {
        logic                 we;
        logic [BHT_IDX_W-1:0] idx;
        logic [1:0]           sel;
        logic                 inc;
        logic                 dec;
        logic                 vld;
    } bht_upd_t;

    typedef struct packed {
        logic                 ce;
        logic                 we;
        logic [BTB_W-1:0]     wmask;
        logic [BTB_IDX_W-1:0] idx;
        logic [BTB_W-1:0]     din;
    } btb_upd_t;

    localparam int BHT_UPD_W = $bits(bht_upd_t);
    localparam int BTB_UPD_W = $bits(btb_upd_t);

    // A cycle carries something worth training on if either array is written.
    function automatic logic is_accept(input bht_upd_t bht, input btb_upd_t btb);
        return bht.we | (btb.ce & btb.we);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bpu_train_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : bpu_train_queue_if
//  Purpose  : Bundles the writeback-side update inputs and the predictor-side
//             training outputs of the training queue.
//  Ports    : in_bht_pkt / in_btb_pkt  - updates from writeback
//             train_valid / train_ready - head handshake to predictor
//             out_bht_pkt / out_btb_pkt - head entry (zero when empty)
//             occupancy, drop_cnt       - status
//  Modports : master - update producer / predictor side
//             slave  - the queue itself
//  Revision : 1.0 - initial release
// ============================================================================
interface bpu_train_queue_if
    import bpu_train_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    bht_upd_t           in_bht_pkt;
    btb_upd_t           in_btb_pkt;
    logic               train_valid;
    logic               train_ready;
    bht_upd_t           out_bht_pkt;
    btb_upd_t           out_btb_pkt;
    logic [OCC_W-1:0]   occupancy;
    logic [DROP_W-1:0]  drop_cnt;

    modport master (
        output in_bht_pkt, in_btb_pkt, train_ready,
        input  train_valid, out_bht_pkt, out_btb_pkt, occupancy, drop_cnt
    );

    modport slave (
        input  in_bht_pkt, in_btb_pkt, train_ready,
        output train_valid, out_bht_pkt, out_btb_pkt, occupancy, drop_cnt
    );

endinterface
`default_nettype wire

// File: rtl/bpu_train_queue_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with wrap-bit pointers. Storage is not reset;
//             only the pointers are, so reset discards any held entries.
//  Ports    : clock, reset_n          - clock, async active-low reset
//             push_i, wdata_i         - write request / data
//             pop_i                   - read request (head advances)
//             rdata_o                 - head entry (valid when !empty_o)
//             full_o, empty_o         - status
//             count_o                 - number of stored entries
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  wire logic                     clock,
    input  wire logic                     reset_n,
    input  wire logic                     push_i,
    input  wire logic                     pop_i,
    input  wire logic [WIDTH-1:0]         wdata_i,
    output logic      [WIDTH-1:0]         rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic      [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    // Full: same slot, opposite lap.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bpu_train_queue.sv
`default_nettype none
// ============================================================================
//  Module   : bpu_train_queue
//  Purpose  : Buffers BHT/BTB training updates from int writeback and drains
//             them into the frontend predictor whenever its SRAM port is free.
//             Updates arriving while full are dropped and counted.
//  Ports    : clock    - core clock
//             reset_n  - asynchronous active-low reset
//             bus      - bpu_train_queue_if.slave (update in, training out,
//                        occupancy, saturating drop counter)
//  Revision : 1.0 - initial release
// ============================================================================
module bpu_train_queue
    import bpu_train_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    bpu_train_queue_if.slave   bus
);
    localparam int OCC_W  = $clog2(DEPTH) + 1;
    localparam int FIFO_W = BHT_UPD_W + BTB_UPD_W;

    logic              accept;
    logic              deq;
    logic              enq;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OCC_W-1:0]  fifo_count;
    logic [FIFO_W-1:0] fifo_wdata;
    logic [FIFO_W-1:0] fifo_rdata;
    bht_upd_t          head_bht;
    btb_upd_t          head_btb;
    logic [DROP_W-1:0] drop_q, drop_d;

    assign accept = is_accept(bus.in_bht_pkt, bus.in_btb_pkt);
    // train_valid comes only from pointer state, never from train_ready.
    assign deq    = ~fifo_empty & bus.train_ready;
    assign enq    = accept & (~fifo_full | deq);
    assign drop   = accept & fifo_full & ~deq;

    // The whole cycle's pair is stored; inner enables are left for the predictor.
    assign fifo_wdata = {bus.in_bht_pkt, bus.in_btb_pkt};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (enq),
        .pop_i   (deq),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign {head_bht, head_btb} = fifo_rdata;

    always_comb begin
        drop_d = drop_q;
        if (drop && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.train_valid = ~fifo_empty;
    // Unwritten/stale storage must never present an enable to the predictor.
    assign bus.out_bht_pkt = fifo_empty ? '0 : head_bht;
    assign bus.out_btb_pkt = fifo_empty ? '0 : head_btb;
    assign bus.occupancy   = fifo_count;
    assign bus.drop_cnt    = drop_q;

endmodule
`default_nettype wire
